// File: rtl/param_memory_pkg.sv
// param_memory_pkg: shared types and constants for the parameterised memory.
//   mem_state_t : init/ready controller state
//   MAX_RD_LAT  : largest supported read latency
package param_memory_pkg;

   typedef enum logic {INIT, READY} mem_state_t;

   localparam int MAX_RD_LAT = 2;

endpackage

// File: rtl/param_memory_rd_pipe.sv
// param_memory_rd_pipe: read-data pipeline for param_memory.
// Stage 0 captures the array word on the accepting edge; stages 1..RD_LAT
// shift it towards the output. Data stages only load behind a valid so the
// output holds the last read word between pulses.
// Ports:
//   clk, rst          : clock, synchronous active-high clear
//   vld_i, data_i     : read accepted this edge, word read from the array
//   vld_o, data_o     : read result pulse and held read data
module param_memory_rd_pipe
   import param_memory_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vld_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              vld_o,
   output logic [DATA_W-1:0] data_o
);

   logic [RD_LAT:0]             vld_q;
   logic [RD_LAT:0][DATA_W-1:0] data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= '0;
         data_q <= '0;
      end else begin
         vld_q <= {vld_q[RD_LAT-1:0], vld_i};
         if (vld_i) data_q[0] <= data_i;
         for (int i = 1; i <= RD_LAT; i++) begin
            if (vld_q[i-1]) data_q[i] <= data_q[i-1];
         end
      end
   end

   assign vld_o  = vld_q[RD_LAT];
   assign data_o = data_q[RD_LAT];

endmodule

// File: rtl/param_memory.sv
// param_memory: single-port synchronous memory with byte-lane writes,
// selectable read latency (1 or 2), self-clearing init after reset and an
// out-of-range error pulse.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   en, wr_en   : request strobe, 1 = write / 0 = read
//   byte_en     : per-byte write enable (ignored on reads)
//   address     : word address
//   data_in     : write data
//   data_out    : read data, held between reads
//   valid_out   : one-cycle pulse per completed read
//   busy        : init sweep in progress, requests ignored
//   err         : one-cycle pulse for a dropped out-of-range request
module param_memory
   import param_memory_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int RD_LAT = 1,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                wr_en,
   input  logic [DATA_W/8-1:0] byte_en,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   data_in,
   output logic [DATA_W-1:0]   data_out,
   output logic                valid_out,
   output logic                busy,
   output logic                err
);

   localparam int                NB       = DATA_W / 8;
   localparam int                IDX_W    = $clog2(DEPTH);
   localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

   generate
      if ((DATA_W % 8) != 0 || RD_LAT < 1 || RD_LAT > MAX_RD_LAT ||
          DEPTH < 2 || ADDR_W < IDX_W) begin : g_bad_cfg
         $fatal(1, "param_memory: illegal DATA_W/RD_LAT/DEPTH/ADDR_W");
      end
   endgenerate

   mem_state_t        state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              err_q;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              acc, in_range, wr_acc, rd_acc;
   logic [IDX_W-1:0]  idx;

   // Zero-extend so addresses wider than the array compare correctly.
   assign in_range = {1'b0, address} < DEPTH_A;
   assign idx      = address[IDX_W-1:0];
   assign acc      = en & (state_q == READY);
   assign wr_acc   = acc & in_range & wr_en;
   assign rd_acc   = acc & in_range & ~wr_en;

   // Init sweep: one word cleared per cycle, leave after the last word.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST_IDX) begin
            state_d = READY;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= acc & ~in_range;
      end
   end

   // Storage has no reset; the init sweep provides the cleared contents.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == INIT) begin
            mem_q[cnt_q] <= '0;
         end else if (wr_acc) begin
            for (int b = 0; b < NB; b++) begin
               if (byte_en[b]) mem_q[idx][b*8 +: 8] <= data_in[b*8 +: 8];
            end
         end
      end
   end

   // The array word is sampled on the accepting edge, so a write on the
   // very next edge cannot disturb an in-flight read.
   param_memory_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk    (clk),
      .rst    (rst),
      .vld_i  (rd_acc),
      .data_i (mem_q[idx]),
      .vld_o  (valid_out),
      .data_o (data_out)
   );

   assign busy = (state_q == INIT);
   assign err  = err_q;

endmodule

// File: doc/param_memory.md
# param_memory

Parameterised single-port synchronous memory, the next generation of the team's `Memory` block. It adds configurable width and depth, byte-lane write enables, and a selectable read latency of 1 or 2 cycles. It also adds a self-clearing initialisation sequence after reset and an out-of-range address error flag. It sits behind the class-based test environment's interface as the storage DUT and is driven through the same `en` / `address` / `data_in` request style.

## Interface
- `DATA_W`, default 32: word width in bits; must be a multiple of 8.
- `DEPTH`, default 16: number of words; need not be a power of two; minimum 2.
- `RD_LAT`, default 1: read latency in cycles; legal values are 1 or 2.
- `ADDR_W`, default `$clog2(DEPTH)`: address width.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `en`  in  1: request strobe.
- `wr_en`  in  1: 1 = write, 0 = read; qualified by `en`.
- `byte_en`  in  DATA_W/8: per-byte write enable; ignored for reads.
- `address`  in  ADDR_W: word address.
- `data_in`  in  DATA_W: write data.
- `data_out`  out  DATA_W: read data.
- `valid_out`  out  1: `data_out` is valid this cycle (one-cycle pulse per read).
- `busy`  out  1: initialisation in progress; requests are ignored.
- `err`  out  1: one-cycle pulse flagging a dropped out-of-range request.

## Operation
- FSM states: `INIT` and `READY`.
  - `rst` = 1 forces `INIT` and sets the init counter to 0.
  - In `INIT`, each cycle with `rst` = 0 writes 0 to `mem[cnt]` and increments `cnt`.
  - When `cnt` = DEPTH-1 is written, the FSM moves to `READY`.
  - `READY` is held until the next `rst`.
- Request acceptance: `en` = 1 and `busy` = 0 at a rising edge.
- Accepted write:
  - For each byte i with `byte_en[i]` = 1, `mem[address]` byte i is updated from `data_in` byte i.
  - Other bytes are unchanged.
  - `byte_en` = 0 writes nothing, is still accepted, and does not raise `err`.
  - No `valid_out` is produced.
- Accepted read: `mem[address]` is captured into the read pipeline.
- Out of range (`address` >= DEPTH): the request is dropped with no storage change and no `valid_out`. `err` = 1 on the following cycle.
- Requests while `busy` = 1 are silently ignored: no `err`, no `valid_out`.
- Read-after-write: a read of an address written in the previous cycle returns the new data.
- `data_out` holds its last read value while `valid_out` = 0.

## Timing
- Reset values: `data_out` = 0, `valid_out` = 0, `err` = 0, `busy` = 1.
- `busy` stays 1 for exactly DEPTH cycles after the first edge with `rst` = 0. The first request can be accepted at edge DEPTH+1.
- Read latency:
  - A read accepted at edge N gives `valid_out` = 1 and `data_out` = word after edge N+RD_LAT.
  - With RD_LAT = 2 the extra stage is an output register.
- Back-to-back reads every cycle give back-to-back `valid_out` pulses in order, at full throughput.
- A read followed immediately by a write to the same address returns the pre-write data.
- `err` latency is 1 cycle, independent of RD_LAT.
- Reset mid-operation:
  - In-flight read-pipeline valids are cleared on the reset edge.
  - `data_out` is cleared to 0.
  - INIT restarts from word 0, and all contents are re-cleared.

## Structure
- `param_memory_pkg`:
  - `typedef enum logic {INIT, READY} mem_state_t`.
  - Constant `MAX_RD_LAT` = 2.
- Sub-module `param_memory_rd_pipe` (parameters DATA_W, RD_LAT):
  - Holds the valid/data shift stages with synchronous clear.
  - Instantiated once.
- Elaboration check: fatal error if DATA_W % 8 != 0 or if RD_LAT is not 1 or 2.

## Test plan
- Reset then idle, DEPTH = 16:
  - `busy` = 1 for 16 cycles after `rst` falls, then 0.
  - Read of addresses 0..15 returns 0 with `valid_out` each.
- Write 0xDEADBEEF to address 5 with `byte_en` = 4'b1111, then read 5:
  - `valid_out` at +1 cycle (RD_LAT = 1) or +2 cycles (RD_LAT = 2).
  - `data_out` = 0xDEADBEEF.
- Write 0x11223344 with `byte_en` = 4'b0101 over 0xDEADBEEF at address 5, then read → 0xDE22BE44.
- Read with `address` = 20 (DEPTH = 16):
  - `err` pulses 1 cycle later.
  - No `valid_out`; `data_out` is unchanged.
- Reads to addresses 1, 2, 3 on consecutive cycles → three consecutive `valid_out` pulses with matching data. Assert `rst` while they are in flight → `valid_out` = 0 next cycle and `busy` = 1.
- Request issued with `en` = 1 during `busy` → ignored: no `err`, no `valid_out`, and the target word reads 0 after init.
